// File: rtl/p4_parte1_rst_pkg.sv
// Shared types and constants for the p4_parte1 reset controller.
// Contents: FSM state enum, slave register addresses, CAUSE bit positions,
// and the slave data width.
package p4_parte1_rst_pkg;

    localparam int unsigned DATA_W = 16;

    // Encodings are visible to software through STATUS[3:2].
    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_SYS_UP = 2'd1,
        ST_RUN    = 2'd2
    } rst_state_e;

    localparam logic ADDR_CAUSE  = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int unsigned CAUSE_POR_BIT  = 0;
    localparam int unsigned CAUSE_REQ_BASE = 1;

endpackage

// File: rtl/p4_parte1_rst_ctrl_if.sv
// Avalon-MM slave bundle for the reset controller register window.
// Signals: address (0=CAUSE, 1=STATUS), chipselect, write_n, writedata, readdata.
// Modports: master (bus initiator), slave (reset controller).
interface p4_parte1_rst_ctrl_if;
    import p4_parte1_rst_pkg::*;

    logic              address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/p4_parte1_rst_sync_bit.sv
// Synchronizer for one asynchronous reset request level, with an optional
// debouncer behind it (macro P4_PARTE1_RST_CTRL_DEBOUNCE_EN, enabled per
// instance through USE_DEB).
// Ports: clk, reset_n (async active-low), d (async level in), q (synced level).
module p4_parte1_rst_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef P4_PARTE1_RST_CTRL_DEBOUNCE_EN
    , parameter int unsigned DEB_CYCLES = 1000
    , parameter bit          USE_DEB    = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    // Plain flop chain; the MSB is the metastability-settled level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef P4_PARTE1_RST_CTRL_DEBOUNCE_EN
    generate
        if (USE_DEB) begin : g_deb
            localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

            logic [DEB_W-1:0] deb_cnt;
            logic             deb_q;

            // Count consecutive cycles the synced level differs from the output;
            // flip the output once it has differed for DEB_CYCLES cycles.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_cnt <= '0;
                    deb_q   <= 1'b0;
                end else if (sync_out == deb_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt <= '0;
                    deb_q   <= sync_out;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end

            assign q = deb_q;
        end else begin : g_nodeb
            assign q = sync_out;
        end
    endgenerate
`else
    assign q = sync_out;
`endif

endmodule

// File: rtl/p4_parte1_rst_ctrl.sv
// Reset controller: synchronizes reset requests (bit0 watchdog, MSB pushbutton),
// holds sys_reset_n low for HOLD_CYCLES after the last request, releases
// cpu_reset_n CPU_DELAY cycles later, and keeps a sticky reset-cause register.
// Ports: clk, reset_n (async active-low power-on), req_in[NUM_REQ],
//        bus (Avalon-MM slave: CAUSE @0 W1C, STATUS @1 RO),
//        sys_reset_n, cpu_reset_n, busy (all registered).
// Optional: P4_PARTE1_RST_CTRL_DEBOUNCE_EN debounces req_in[NUM_REQ-1].
module p4_parte1_rst_ctrl
    import p4_parte1_rst_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CPU_DELAY   = 8
`ifdef P4_PARTE1_RST_CTRL_DEBOUNCE_EN
    , parameter int unsigned DEB_CYCLES = 1000
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_in,
    p4_parte1_rst_ctrl_if.slave  bus,
    output logic                 sys_reset_n,
    output logic                 cpu_reset_n,
    output logic                 busy
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > CPU_DELAY) ? HOLD_CYCLES : CPU_DELAY;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CPU_RELOAD  = CNT_W'(CPU_DELAY - 1);
    localparam logic [DATA_W-1:0] CAUSE_RST   = DATA_W'(1) << CAUSE_POR_BIT;

    logic [NUM_REQ-1:0] req_s;
    logic               any_req;

    rst_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  cause_q;
    logic [DATA_W-1:0]  cause_set_c, cause_clr_c, status_c;
    logic               cause_wr_c;

    // One synchronizer (plus optional debouncer on the pushbutton) per request.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            p4_parte1_rst_sync_bit #(
                .SYNC_STAGES (SYNC_STAGES)
`ifdef P4_PARTE1_RST_CTRL_DEBOUNCE_EN
                , .DEB_CYCLES (DEB_CYCLES)
                , .USE_DEB    (i == NUM_REQ - 1)
`endif
            ) u_sync (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (req_in[i]),
                .q       (req_s[i])
            );
        end
    endgenerate

    assign any_req = |req_s;

    // State, counter and reset outputs; outputs follow next state so they
    // change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= HOLD_RELOAD;
            sys_reset_n <= 1'b0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_n <= (state_d != ST_HOLD);
            cpu_reset_n <= (state_d == ST_RUN);
            busy        <= (state_d != ST_RUN);
        end
    end

    // Sequencing: any request always returns to HOLD with a fresh hold count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_HOLD: begin
                if (any_req) begin
                    cnt_d = HOLD_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_SYS_UP;
                    cnt_d   = CPU_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SYS_UP: begin
                if (any_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (any_req) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_RELOAD;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_RELOAD;
            end
        endcase
    end

    // CAUSE update terms: sticky request bits, W1C clear, set wins over clear.
    always_comb begin
        cause_set_c = '0;
        cause_set_c[CAUSE_REQ_BASE +: NUM_REQ] = req_s;
        cause_wr_c  = bus.chipselect && !bus.write_n && (bus.address == ADDR_CAUSE);
        cause_clr_c = cause_wr_c ? bus.writedata : '0;
        status_c        = '0;
        status_c[0]     = sys_reset_n;
        status_c[1]     = cpu_reset_n;
        status_c[3:2]   = state_q;
    end

    // Cause register and registered read port; only reset_n clears POR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q      <= CAUSE_RST;
            bus.readdata <= '0;
        end else begin
            cause_q      <= (cause_q & ~cause_clr_c) | cause_set_c;
            bus.readdata <= (bus.address == ADDR_STATUS) ? status_c : cause_q;
        end
    end

endmodule

// File: tb/tb_p4_parte1_rst_ctrl.sv
// Self-checking bench for p4_parte1_rst_ctrl with default parameters.
module tb_p4_parte1_rst_ctrl;

    logic       clk;
    logic       reset_n;
    logic [1:0] req_in;
    logic       sys_reset_n;
    logic       cpu_reset_n;
    logic       busy;

    int unsigned n_chk;
    int unsigned n_pass;

    p4_parte1_rst_ctrl_if bus_if ();

    p4_parte1_rst_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .bus         (bus_if),
        .sys_reset_n (sys_reset_n),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy)
    );

    typedef struct {
        int unsigned steps;
        logic        addr;
        logic        exp_sys;
        logic        exp_cpu;
        logic        exp_busy;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t pon_vec [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Pulse req_in[idx] for w edges and check every edge up to n_edges against
    // the expected hold/release timeline (assert at edge 3, sys up at w+18,
    // cpu up at w+26 counted from the edge after the pulse starts).
    task automatic run_pulse(input int idx, input int w, input int n_edges,
                             input logic pre_sys, input logic pre_cpu, input string tag);
        logic es, ec;
        req_in[idx] = 1'b1;
        for (int e = 1; e <= n_edges; e++) begin
            step();
            if (e == w) req_in[idx] = 1'b0;
            es = (e < 3) ? pre_sys : (e >= w + 18);
            ec = (e < 3) ? pre_cpu : (e >= w + 26);
            chk($sformatf("%s_sys_e%0d", tag, e),  16'(sys_reset_n), 16'(es));
            chk($sformatf("%s_cpu_e%0d", tag, e),  16'(cpu_reset_n), 16'(ec));
            chk($sformatf("%s_busy_e%0d", tag, e), 16'(busy),        16'(!ec));
        end
    endtask

    task automatic bus_write(input logic a, input logic cs, input logic [15:0] d);
        bus_if.address    = a;
        bus_if.chipselect = cs;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        step();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset_n = 1'b0;
        req_in  = '0;
        bus_if.address    = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        // steps, addr, sys, cpu, busy, readdata
        pon_vec[0] = '{0,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        pon_vec[1] = '{15, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001};
        pon_vec[2] = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        pon_vec[3] = '{7,  1'b1, 1'b1, 1'b0, 1'b1, 16'h0005};
        pon_vec[4] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 16'h0005};
        pon_vec[5] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 16'h000B};
        pon_vec[6] = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 16'h0001};

        repeat (3) step();
        reset_n = 1'b1;

        // Power-on sequence: sys at edge 16, cpu at edge 24.
        for (int i = 0; i < 7; i++) begin
            bus_if.address = pon_vec[i].addr;
            for (int unsigned s = 0; s < pon_vec[i].steps; s++) step();
            chk($sformatf("pon%0d_sys", i),  16'(sys_reset_n),   16'(pon_vec[i].exp_sys));
            chk($sformatf("pon%0d_cpu", i),  16'(cpu_reset_n),   16'(pon_vec[i].exp_cpu));
            chk($sformatf("pon%0d_busy", i), 16'(busy),          16'(pon_vec[i].exp_busy));
            chk($sformatf("pon%0d_rd", i),   bus_if.readdata,    pon_vec[i].exp_rd);
        end

        // Watchdog 2-cycle pulse from RUN.
        run_pulse(0, 2, 28, 1'b1, 1'b1, "wdt");
        bus_if.address = 1'b0;
        step();
        chk("cause_after_wdt", bus_if.readdata, 16'h0003);

        // Pushbutton held 40 cycles; stop just after entering SYS_UP.
        run_pulse(1, 40, 59, 1'b1, 1'b1, "ext");
        chk("cause_after_ext", bus_if.readdata, 16'h0007);

        // Watchdog pulse during SYS_UP: full hold restarts, cpu never released early.
        run_pulse(0, 2, 28, 1'b1, 1'b0, "sysup");

        // Ignored writes: chipselect low, and STATUS address.
        bus_write(1'b0, 1'b0, 16'hFFFF);
        step();
        chk("cause_cs_low_write", bus_if.readdata, 16'h0007);
        bus_write(1'b1, 1'b1, 16'hFFFF);
        bus_if.address = 1'b0;
        step();
        chk("cause_status_write", bus_if.readdata, 16'h0007);

        // W1C clears everything written.
        bus_write(1'b0, 1'b1, 16'h0007);
        step();
        chk("cause_w1c_all", bus_if.readdata, 16'h0000);

        // Clear of bit1 in the same cycle req_s[0] sets it: set wins.
        req_in[0] = 1'b1;
        step();
        req_in[0] = 1'b0;
        step();
        bus_write(1'b0, 1'b1, 16'h0003);
        step();
        chk("cause_set_wins", bus_if.readdata, 16'h0002);
        chk("sys_low_after_1cyc", 16'(sys_reset_n), 16'h0000);

        // Run to RUN (1-cycle pulse: cpu up at edge 27 from pulse start).
        repeat (23) step();
        chk("run_cpu_after_1cyc", 16'(cpu_reset_n), 16'h0001);
        chk("run_rd_before_rst", bus_if.readdata, 16'h0002);

        // Asynchronous reset_n from RUN: immediate return to reset values.
        reset_n = 1'b0;
        #1;
        chk("arst_sys",  16'(sys_reset_n), 16'h0000);
        chk("arst_cpu",  16'(cpu_reset_n), 16'h0000);
        chk("arst_busy", 16'(busy),        16'h0001);
        chk("arst_rd",   bus_if.readdata,  16'h0000);
        step();
        step();
        reset_n = 1'b1;
        bus_if.address = 1'b0;
        step();
        chk("arst_cause_por", bus_if.readdata, 16'h0001);
        chk("arst_sys_edge1", 16'(sys_reset_n), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
